// File: rtl/mem_bank_if.sv
// Main-bus / memory-bank handshake bundle for mem_bank_ctrl.
// master drives requests and bus data, slave is the controller.
interface mem_bank_if #(
  parameter int WIDTH_ADDR = 16,
  parameter int WIDTH      = 8,
  parameter int BW         = 2
);
  logic [WIDTH_ADDR-1:0] addr_in;
  logic                  bus_dir;
  logic [WIDTH-1:0]      main_in;
  logic                  assert_main;
  logic                  load_main;
  logic                  req;
  logic [BW-1:0]         bank_in;
  logic                  bank_load;
  logic                  ready;
  logic                  busy;
  logic                  wp_err;
  logic [BW-1:0]         bank_out;
  logic [WIDTH-1:0]      main_out;
  logic                  main_en;
  logic [WIDTH-1:0]      bus_out;

  modport master (
    output addr_in, bus_dir, main_in, assert_main,
    output load_main, req, bank_in, bank_load,
    input  ready, busy, wp_err, bank_out,
    input  main_out, main_en, bus_out
  );

  modport slave (
    input  addr_in, bus_dir, main_in, assert_main,
    input  load_main, req, bank_in, bank_load,
    output ready, busy, wp_err, bank_out,
    output main_out, main_en, bus_out
  );
endinterface

// File: rtl/mem_bank_ctrl.sv
// Banked memory controller with wait states, bank register
// and write protection of the low region of bank 0.
module mem_bank_ctrl #(
  parameter int WIDTH_ADDR  = 16,
  parameter int WIDTH       = 8,
  parameter int DEPTH_LOG2  = 12,
  parameter int NUM_BANKS   = 4,
  parameter int WAIT_STATES = 1,
  parameter int RO_TOP      = 256
) (
  input logic       clk,
  input logic       rst_n,
  mem_bank_if.slave bus
);
  localparam int BW = $clog2(NUM_BANKS);
  localparam int AW = BW + DEPTH_LOG2;
  localparam int NW = NUM_BANKS * (2 ** DEPTH_LOG2);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic                  c_dir;
  logic                  c_load;
  logic [WIDTH-1:0]      c_data;
  logic [BW-1:0]         c_bank;
  logic [BW-1:0]         bank_q;
  logic [WIDTH-1:0]      rd_q;
  logic                  wp_q;

  logic [WIDTH-1:0] mem [NW];

  logic [AW-1:0] maddr;
  logic [31:0]   idx32;
  logic          last;
  logic          wr_try;
  logic          prot;
  logic          wr_en;
  logic          unused_addr;

  assign maddr  = {c_bank, c_idx};
  assign idx32  = 32'(c_idx);
  assign last   = (state == ACCESS) && (cnt == 4'd0);
  assign wr_try = last && !c_dir && !c_load;
  assign prot   = (c_bank == '0) && (idx32 < 32'(RO_TOP));
  assign wr_en  = wr_try && !prot;

  // upper address bits only matter for wrap-around, never stored
  assign unused_addr = ^bus.addr_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      c_idx  <= '0;
      c_dir  <= 1'b0;
      c_load <= 1'b0;
      c_data <= '0;
      c_bank <= '0;
      bank_q <= '0;
      rd_q   <= '0;
      wp_q   <= 1'b0;
    end else begin
      if (bus.bank_load) bank_q <= bus.bank_in;
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            state  <= ACCESS;
            cnt    <= 4'(WAIT_STATES);
            c_idx  <= bus.addr_in[DEPTH_LOG2-1:0];
            c_dir  <= bus.bus_dir;
            c_load <= bus.load_main;
            c_data <= bus.main_in;
            c_bank <= bank_q;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state <= DONE;
            if (c_dir) rd_q <= mem[maddr];
            if (wr_try && prot) wp_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // contents are never reset; reset forces IDLE so no write slips through
  always_ff @(posedge clk) begin
    if (wr_en) mem[maddr] <= c_data;
  end

  assign bus.ready    = (state == DONE);
  assign bus.busy     = (state != IDLE);
  assign bus.wp_err   = wp_q;
  assign bus.bank_out = bank_q;
  assign bus.bus_out  = rd_q;
  assign bus.main_out = bus.bus_dir ? rd_q : bus.main_in;
  assign bus.main_en  = bus.bus_dir && !bus.assert_main;
endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Directed self-checking bench for mem_bank_ctrl.
// Main instance runs 1 wait state, second instance runs 0.
module tb_mem_bank_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass = 0;
  int   total = 0;

  always #5 clk = ~clk;

  mem_bank_if #(.WIDTH_ADDR(16), .WIDTH(8), .BW(2)) f ();
  mem_bank_if #(.WIDTH_ADDR(16), .WIDTH(8), .BW(2)) f0 ();

  mem_bank_ctrl #(.WAIT_STATES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(f)
  );
  mem_bank_ctrl #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(f0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic load_bank(input logic [1:0] b);
    f.bank_in = b;
    f.bank_load = 1'b1;
    @(negedge clk);
    f.bank_load = 1'b0;
  endtask

  // called at a negedge; returns at the negedge where ready is seen
  task automatic access(input logic dir, input logic [15:0] a,
                        input logic [7:0] d, output int lat);
    f.addr_in = a;
    f.bus_dir = dir;
    f.main_in = d;
    f.load_main = 1'b0;
    f.req = 1'b1;
    @(posedge clk);
    #1 f.req = 1'b0;
    f.bank_load = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (f.ready) break;
      @(posedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    logic [8:0] rb;
    logic [8:0] bb;
    logic me_bad;

    f.addr_in = '0; f.bus_dir = 1'b0; f.main_in = '0;
    f.assert_main = 1'b1; f.load_main = 1'b0; f.req = 1'b0;
    f.bank_in = '0; f.bank_load = 1'b0;
    f0.addr_in = '0; f0.bus_dir = 1'b0; f0.main_in = '0;
    f0.assert_main = 1'b1; f0.load_main = 1'b0; f0.req = 1'b0;
    f0.bank_in = '0; f0.bank_load = 1'b0;

    nxt(); nxt();
    chk("rst_ready", f.ready, 0);
    chk("rst_busy", f.busy, 0);
    chk("rst_wp", f.wp_err, 0);
    chk("rst_bank", f.bank_out, 0);
    chk("rst_busout", f.bus_out, 0);

    rst_n = 1'b1;
    access(1'b0, 16'h0100, 8'h5A, lat);
    chk("first_req_lat", lat, 3);
    chk("done_busy", f.busy, 1);
    chk("first_wp", f.wp_err, 0);
    nxt();
    chk("ready_one_cycle", f.ready, 0);
    chk("idle_busy", f.busy, 0);

    load_bank(2'd1);
    chk("bank_load1", f.bank_out, 1);
    access(1'b0, 16'h0010, 8'hA5, lat);
    chk("wr_lat", lat, 3);
    nxt();
    access(1'b1, 16'h0010, 8'h00, lat);
    chk("rd_lat", lat, 3);
    chk("rd_busout", f.bus_out, 8'hA5);
    chk("rd_mainout", f.main_out, 8'hA5);
    nxt();

    access(1'b0, 16'h1005, 8'h3C, lat);
    nxt();
    access(1'b1, 16'h0005, 8'h00, lat);
    chk("wrap", f.bus_out, 8'h3C);
    nxt();

    load_bank(2'd2);
    f.bank_in = 2'd3;
    f.bank_load = 1'b1;
    access(1'b0, 16'h0040, 8'h11, lat);
    chk("same_edge_bank", f.bank_out, 3);
    nxt();
    access(1'b0, 16'h0040, 8'h22, lat);
    nxt();
    access(1'b1, 16'h0040, 8'h00, lat);
    chk("bank3_rd", f.bus_out, 8'h22);
    nxt();
    load_bank(2'd2);
    access(1'b1, 16'h0040, 8'h00, lat);
    chk("bank2_rd", f.bus_out, 8'h11);
    nxt();

    load_bank(2'd0);
    access(1'b0, 16'h0020, 8'hFF, lat);
    chk("wp_set", f.wp_err, 1);
    nxt();
    access(1'b1, 16'h0020, 8'h00, lat);
    chk("wp_unchanged", f.bus_out === 8'hFF, 0);
    nxt();
    access(1'b0, 16'h0100, 8'h66, lat);
    nxt();
    access(1'b1, 16'h0100, 8'h00, lat);
    chk("wp_edge_rd", f.bus_out, 8'h66);
    chk("wp_sticky", f.wp_err, 1);
    nxt();

    load_bank(2'd1);
    f.addr_in = 16'h0010;
    f.bus_dir = 1'b0;
    f.main_in = 8'h77;
    f.req = 1'b1;
    @(posedge clk);
    #1 f.req = 1'b0;
    @(negedge clk);
    chk("abort_busy_pre", f.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", f.ready, 0);
    chk("abort_busy", f.busy, 0);
    chk("abort_wp", f.wp_err, 0);
    chk("abort_bank", f.bank_out, 0);
    chk("abort_busout", f.bus_out, 0);
    chk("abort_mainen", f.main_en, 0);
    pulses = 0;
    nxt();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      if (f.ready) pulses++;
    end
    chk("abort_no_ready", pulses, 0);
    load_bank(2'd1);
    access(1'b1, 16'h0010, 8'h00, lat);
    chk("abort_keep", f.bus_out, 8'hA5);
    nxt();

    f.bus_dir = 1'b1; f.assert_main = 1'b0;
    #1 chk("mainen_on", f.main_en, 1);
    f.assert_main = 1'b1;
    #1 chk("mainen_off", f.main_en, 0);
    f.bus_dir = 1'b0; f.assert_main = 1'b0; f.main_in = 8'h3E;
    #1 chk("mainen_wr", f.main_en, 0);
    chk("mainout_wr", f.main_out, 8'h3E);

    nxt();
    f0.bus_dir = 1'b1;
    f0.assert_main = 1'b1;
    f0.req = 1'b1;
    rb = '0; bb = '0; me_bad = 1'b0;
    for (int i = 0; i < 9; i++) begin
      nxt();
      rb[i] = f0.ready;
      bb[i] = f0.busy;
      if (f0.main_en) me_bad = 1'b1;
    end
    f0.req = 1'b0;
    chk("ws0_ready_seq", rb, 9'b010010010);
    chk("ws0_busy_seq", bb, 9'b011011011);
    chk("ws0_mainen", me_bad, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
